count_capture: RTL and testbench



---
 rtl/count_capture_pkg.sv | 27 ++
 rtl/capture_fifo.sv | 57 +++++
 rtl/count_capture.sv | 89 ++++++++
 tb/tb_count_capture.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/count_capture_pkg.sv
// Shared widths, FIFO entry layout and helpers for count_capture.
// The wrap bit exists only when COUNT_CAPTURE_WRAP_DETECT_EN is defined.
package count_capture_pkg;

    localparam int CNT_W_DEF = 4;
    localparam int TS_W_DEF  = 8;
    localparam int DEPTH_DEF = 8;

    typedef struct packed {
        logic [CNT_W_DEF-1:0] count;
        logic [TS_W_DEF-1:0]  delta;
`ifdef COUNT_CAPTURE_WRAP_DETECT_EN
        logic                 wrap;
`endif
    } capture_entry_t;

    function automatic logic [TS_W_DEF-1:0] sat_inc(input logic [TS_W_DEF-1:0] v);
        logic [TS_W_DEF-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + TS_W_DEF'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/capture_fifo.sv
// Synchronous FIFO of capture entries; pointers carry an extra lap bit so
// full and empty are distinguishable and level is a plain subtraction.
module capture_fifo
    import count_capture_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  capture_entry_t           din,
    output capture_entry_t           dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]    wr_ptr_r;
    logic [AW:0]    rd_ptr_r;
    capture_entry_t mem_r [DEPTH];
    logic           wr_en_s;
    logic           rd_en_s;

    // A pop frees the head slot in the same edge, so full+pop still accepts a push.
    assign wr_en_s = push && (!full || pop);
    assign rd_en_s = pop && !empty;
    assign level   = wr_ptr_r - rd_ptr_r;
    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (wr_ptr_r == rd_ptr_r);
    assign dout    = empty ? capture_entry_t'('0) : mem_r[rd_ptr_r[AW-1:0]];

    // Pointer registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end
        end
    end

    // Entry storage
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/count_capture.sv
// Records every change of the observed count as {value, delta, wrap} in a FIFO.
// Wrap detection is built only with COUNT_CAPTURE_WRAP_DETECT_EN defined.
module count_capture
    import count_capture_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int TS_W  = TS_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cap_en,
    input  logic [CNT_W-1:0]       count,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CNT_W-1:0]       out_count,
    output logic [TS_W-1:0]        out_delta,
    output logic                   out_wrap,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    input  logic                   clr_ovf
);

    logic [CNT_W-1:0] prev_count_r;
    logic [TS_W-1:0]  ts_r;
    logic             overflow_r;
    logic             chg_s;
    logic [TS_W-1:0]  delta_s;
    logic             push_s;
    logic             pop_s;
    logic             drop_s;
    logic             full_s;
    logic             empty_s;
    capture_entry_t   entry_s;
    capture_entry_t   head_s;

    assign chg_s   = (count != prev_count_r);
    assign delta_s = sat_inc(ts_r);
    assign push_s  = chg_s && cap_en;
    assign pop_s   = out_valid && out_ready;
    assign drop_s  = push_s && full_s && !pop_s;

    assign entry_s.count = count;
    assign entry_s.delta = delta_s;
`ifdef COUNT_CAPTURE_WRAP_DETECT_EN
    assign entry_s.wrap  = (&prev_count_r) && (count == CNT_W'(0));
    assign out_wrap      = head_s.wrap;
`else
    assign out_wrap      = 1'b0;
`endif

    assign out_valid = !empty_s;
    assign out_count = head_s.count;
    assign out_delta = head_s.delta;
    assign overflow  = overflow_r;

    // Change tracking, delta timer and sticky overflow; ts restarts on every change
    // even when the entry is suppressed or dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_count_r <= '0;
            ts_r         <= '0;
            overflow_r   <= 1'b0;
        end else begin
            prev_count_r <= count;
            ts_r         <= chg_s ? TS_W'(0) : delta_s;
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (clr_ovf) begin
                overflow_r <= 1'b0;
            end
        end
    end

    capture_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .din   (entry_s),
        .dout  (head_s),
        .full  (full_s),
        .empty (empty_s),
        .level (level)
    );

endmodule

// File: tb/tb_count_capture.sv
// Self-checking bench for count_capture: directed scenarios then random traffic,
// compared against a queue-based reference model (honours COUNT_CAPTURE_WRAP_DETECT_EN).
module tb_count_capture;

    localparam int DEPTH = 8;
    localparam int TSMAX = 255;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cap_en = 1'b0;
    logic [3:0] count = 4'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_count;
    logic [7:0] out_delta;
    logic       out_wrap;
    logic [3:0] level;
    logic       overflow;
    logic       clr_ovf = 1'b0;

    count_capture dut (
        .clk       (clk),
        .rst       (rst),
        .cap_en    (cap_en),
        .count     (count),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .out_delta (out_delta),
        .out_wrap  (out_wrap),
        .level     (level),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    always #5 clk = ~clk;

    typedef struct { int c; int d; int w; } ent_t;
    ent_t q[$];
    int   m_prev;
    int   edge_no;
    int   last_chg;
    int   m_ovf;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_prev   = 0;
        edge_no  = 0;
        last_chg = 0;
        m_ovf    = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".valid"}, {31'd0, out_valid}, (q.size() != 0) ? 32'd1 : 32'd0);
        chk({tag, ".level"}, {28'd0, level}, q.size());
        chk({tag, ".ovf"}, {31'd0, overflow}, m_ovf);
        if (q.size() != 0) begin
            chk({tag, ".count"}, {28'd0, out_count}, q[0].c);
            chk({tag, ".delta"}, {24'd0, out_delta}, q[0].d);
            chk({tag, ".wrap"}, {31'd0, out_wrap}, q[0].w);
        end
    endtask

    // One clock: drive on the falling edge, advance the model, check just after the rising edge.
    task automatic step(input int c, input logic ce, input logic rdy, input logic clr, input string tag);
        ent_t e;
        bit   pop;
        @(negedge clk);
        count = 4'(c); cap_en = ce; out_ready = rdy; clr_ovf = clr;
        edge_no++;
        pop = (q.size() != 0) && rdy;
        if (pop) void'(q.pop_front());
        if (c != m_prev) begin
            e.c = c;
            e.d = (edge_no - last_chg > TSMAX) ? TSMAX : edge_no - last_chg;
`ifdef COUNT_CAPTURE_WRAP_DETECT_EN
            e.w = (m_prev == 15 && c == 0) ? 1 : 0;
`else
            e.w = 0;
`endif
            last_chg = edge_no;
            if (ce) begin
                if (q.size() < DEPTH) q.push_back(e);
                else m_ovf = 1;
            end
        end
        if (clr && !(ce && c != m_prev && q.size() == DEPTH && !pop)) m_ovf = 0;
        m_prev = c;
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    // Reset asserted mid-cycle; outputs must clear before any further clock edge.
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        count = 4'd0; cap_en = 1'b1; out_ready = 1'b1; clr_ovf = 1'b0;
        #1;
        model_reset();
        chk("rst.valid", {31'd0, out_valid}, 32'd0);
        chk("rst.level", {28'd0, level}, 32'd0);
        chk("rst.count", {28'd0, out_count}, 32'd0);
        chk("rst.delta", {24'd0, out_delta}, 32'd0);
        chk("rst.wrap", {31'd0, out_wrap}, 32'd0);
        chk("rst.ovf", {31'd0, overflow}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        int c;
        model_reset();
        do_reset();

        // first change three edges after release -> {1,3,0}, visible for one cycle
        step(0, 1'b1, 1'b1, 1'b0, "t1a");
        step(0, 1'b1, 1'b1, 1'b0, "t1b");
        step(1, 1'b1, 1'b1, 1'b0, "t1c");
        chk("t1.delta3", {24'd0, out_delta}, 32'd3);
        step(1, 1'b1, 1'b1, 1'b0, "t1d");

        // 14 -> 15 -> 0 with a held consumer so both entries are inspected
        step(14, 1'b1, 1'b0, 1'b0, "t2a");
        step(15, 1'b1, 1'b1, 1'b0, "t2b");
        step(0, 1'b1, 1'b1, 1'b0, "t2c");
        step(0, 1'b1, 1'b1, 1'b0, "t2d");
        step(0, 1'b1, 1'b1, 1'b0, "t2e");

        // nine changes into a stalled FIFO, then clear overflow
        for (int i = 1; i <= 9; i++) step(i, 1'b1, 1'b0, 1'b0, "t3fill");
        chk("t3.level8", {28'd0, level}, 32'd8);
        chk("t3.ovf", {31'd0, overflow}, 32'd1);
        step(9, 1'b1, 1'b0, 1'b1, "t3clr");
        chk("t3.ovfclr", {31'd0, overflow}, 32'd0);

        // change and pop together while full
        step(12, 1'b1, 1'b1, 1'b0, "t4push_pop");
        chk("t4.level8", {28'd0, level}, 32'd8);
        for (int i = 0; i < 8; i++) step(12, 1'b1, 1'b1, 1'b0, "t4drain");

        // saturated delta, then a suppressed change
        for (int i = 0; i < 300; i++) step(12, 1'b1, 1'b1, 1'b0, "t5idle");
        step(3, 1'b1, 1'b0, 1'b0, "t5sat");
        chk("t5.delta255", {24'd0, out_delta}, 32'd255);
        step(3, 1'b1, 1'b1, 1'b0, "t5pop");
        step(5, 1'b0, 1'b1, 1'b0, "t5supp");
        step(5, 1'b1, 1'b1, 1'b0, "t5w1");
        step(6, 1'b1, 1'b0, 1'b0, "t5next");
        chk("t5.delta2", {24'd0, out_delta}, 32'd2);

        // queue five entries then reset mid-cycle
        for (int i = 7; i < 11; i++) step(i, 1'b1, 1'b0, 1'b0, "t6fill");
        chk("t6.level5", {28'd0, level}, 32'd5);
        do_reset();
        step(0, 1'b1, 1'b1, 1'b0, "t6post");
        chk("t6.noentry", {31'd0, out_valid}, 32'd0);

        // random traffic; incrementing runs make wraps likely
        c = 0;
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 3))
                0:       c = c;
                1:       c = (c + 1) % 16;
                2:       c = $urandom_range(0, 15);
                default: c = (c + 1) % 16;
            endcase
            step(c, ($urandom_range(0, 7) != 0), ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 15) == 0), "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
